// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared opcodes and operand-fetch state encoding
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE,
        READ_RS1,
        GAP,
        READ_RS2,
        HOLD
    } opfetch_state_e;

    function automatic logic is_read_state(input opfetch_state_e s);
        return (s == READ_RS1) || (s == READ_RS2);
    endfunction

endpackage

// File: rtl/rv32i_operand_fetch_if.sv
// rtl/rv32i_operand_fetch_if.sv - decode/regfile/execute signal bundle around operand fetch
interface rv32i_operand_fetch_if #(
    parameter int WIDTH = 32
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             rf_rd_en;
    logic [4:0]       rf_reg_addr;
    logic [WIDTH-1:0] rf_reg_data;
    logic             rf_rd_valid;
    logic             op_valid;
    logic             op_ready;
    logic [31:0]      op_instr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             err;

    modport master (
        output instr_valid, instr, rf_reg_data, rf_rd_valid, op_ready,
        input  instr_ready, rf_rd_en, rf_reg_addr, op_valid, op_instr,
               rs1_data, rs2_data, err
    );

    modport slave (
        input  instr_valid, instr, rf_reg_data, rf_rd_valid, op_ready,
        output instr_ready, rf_rd_en, rf_reg_addr, op_valid, op_instr,
               rs1_data, rs2_data, err
    );
endinterface

// File: rtl/rv32i_src_decode.sv
// rtl/rv32i_src_decode.sv - which register sources an RV32I instruction reads
module rv32i_src_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic        need_rs1,
    output logic        need_rs2,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr
);
    logic [6:0] opcode;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       unused_fields;

    assign opcode   = instr[6:0];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    // x0 always reads as zero, so it never costs a register-file access
    assign need_rs1 = uses_rs1 && (rs1_addr != 5'd0);
    assign need_rs2 = uses_rs2 && (rs2_addr != 5'd0);

    assign unused_fields = ^{instr[31:25], instr[14:7]};
endmodule

// File: rtl/rv32i_operand_fetch.sv
// rtl/rv32i_operand_fetch.sv - sequences rs1/rs2 reads over a single-port register file
module rv32i_operand_fetch
    import rv32i_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RD_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr,
    output logic             o_instr_ready,
    output logic             o_rf_rd_en,
    output logic [4:0]       o_rf_reg_addr,
    input  logic [WIDTH-1:0] i_rf_reg_data,
    input  logic             i_rf_rd_valid,
    output logic             o_op_valid,
    input  logic             i_op_ready,
    output logic [31:0]      o_instr,
    output logic [WIDTH-1:0] o_rs1_data,
    output logic [WIDTH-1:0] o_rs2_data,
    output logic             o_err
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    opfetch_state_e state_q;
    opfetch_state_e next_state;

    logic [31:0]      instr_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_inc;
    logic             accept;
    logic             in_read;
    logic             timeout;

    logic [31:0] dec_instr;
    logic        dec_need_rs1;
    logic        dec_need_rs2;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;

    logic        rd_en_d;
    logic [4:0]  addr_d;
    logic        op_valid_d;
    logic        err_d;

    // In IDLE the offered instruction is decoded; afterwards the captured one
    assign dec_instr = (state_q == IDLE) ? i_instr : instr_q;

    rv32i_src_decode u_src_decode (
        .instr    (dec_instr),
        .need_rs1 (dec_need_rs1),
        .need_rs2 (dec_need_rs2),
        .rs1_addr (dec_rs1_addr),
        .rs2_addr (dec_rs2_addr)
    );

    assign accept  = i_instr_valid && (state_q == IDLE);
    assign in_read = is_read_state(state_q);
    assign tmo_inc = tmo_cnt + 1'b1;
    // A read-valid in the final allowed cycle still completes the read
    assign timeout = in_read && !i_rf_rd_valid && (tmo_inc == CNT_W'(RD_TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_need_rs1)      next_state = READ_RS1;
                    else if (dec_need_rs2) next_state = READ_RS2;
                    else                   next_state = HOLD;
                end
            end
            READ_RS1: begin
                if (i_rf_rd_valid)  next_state = dec_need_rs2 ? GAP : HOLD;
                else if (timeout)   next_state = IDLE;
            end
            GAP:      next_state = READ_RS2;
            READ_RS2: begin
                if (i_rf_rd_valid)  next_state = HOLD;
                else if (timeout)   next_state = IDLE;
            end
            HOLD: begin
                if (i_op_ready)     next_state = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        rd_en_d    = is_read_state(next_state);
        op_valid_d = (next_state == HOLD);
        err_d      = timeout;
        addr_d     = o_rf_reg_addr;
        // The address only moves on entry to a read, so it is stable under rd_en
        if (state_q == IDLE) begin
            if (next_state == READ_RS1)      addr_d = dec_rs1_addr;
            else if (next_state == READ_RS2) addr_d = dec_rs2_addr;
        end else if (state_q == GAP) begin
            addr_d = dec_rs2_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rf_rd_en    <= 1'b0;
            o_rf_reg_addr <= 5'd0;
            o_op_valid    <= 1'b0;
            o_err         <= 1'b0;
            instr_q       <= 32'd0;
            o_rs1_data    <= '0;
            o_rs2_data    <= '0;
            tmo_cnt       <= '0;
        end else begin
            o_rf_rd_en    <= rd_en_d;
            o_rf_reg_addr <= addr_d;
            o_op_valid    <= op_valid_d;
            o_err         <= err_d;

            if (accept) begin
                instr_q    <= i_instr;
                o_rs1_data <= '0;
                o_rs2_data <= '0;
            end
            if ((state_q == READ_RS1) && i_rf_rd_valid) o_rs1_data <= i_rf_reg_data;
            if ((state_q == READ_RS2) && i_rf_rd_valid) o_rs2_data <= i_rf_reg_data;

            if ((next_state != state_q) || !in_read) tmo_cnt <= '0;
            else                                     tmo_cnt <= tmo_inc;
        end
    end

    assign o_instr_ready = (state_q == IDLE);
    assign o_instr       = instr_q;
endmodule

// File: tb/tb_rv32i_operand_fetch.sv
// tb/tb_rv32i_operand_fetch.sv - randomized operand-fetch bench with a transaction-level model
module tb_rv32i_operand_fetch;
    localparam int WIDTH      = 32;
    localparam int RD_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_operand_fetch_if #(.WIDTH(WIDTH)) bus ();

    rv32i_operand_fetch #(.WIDTH(WIDTH), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_valid (bus.instr_valid),
        .i_instr       (bus.instr),
        .o_instr_ready (bus.instr_ready),
        .o_rf_rd_en    (bus.rf_rd_en),
        .o_rf_reg_addr (bus.rf_reg_addr),
        .i_rf_reg_data (bus.rf_reg_data),
        .i_rf_rd_valid (bus.rf_rd_valid),
        .o_op_valid    (bus.op_valid),
        .i_op_ready    (bus.op_ready),
        .o_instr       (bus.op_instr),
        .o_rs1_data    (bus.rs1_data),
        .o_rs2_data    (bus.rs2_data),
        .o_err         (bus.err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] regs [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Source-operand rules straight from the ISA: which fields are register reads
    function automatic void model_needs(input logic [31:0] ins, output logic n1, output logic n2);
        logic [6:0] opc;
        opc = ins[6:0];
        n1 = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111}) && (ins[19:15] != 5'd0);
        n2 = (opc inside {7'b0110011, 7'b0100011, 7'b1100011}) && (ins[24:20] != 5'd0);
    endfunction

    task automatic serve(input logic [4:0] a, input int n);
        for (int k = 1; k <= n; k++) begin
            check("rd_en", bus.rf_rd_en, 1);
            check("rd_addr", bus.rf_reg_addr, a);
            check("op_valid_early", bus.op_valid, 0);
            bus.rf_rd_valid = (k == n);
            bus.rf_reg_data = (k == n) ? regs[a] : $urandom;
            @(negedge clk);
        end
        bus.rf_rd_valid = 1'b0;
    endtask

    task automatic accept_instr(input logic [31:0] ins);
        check("instr_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int n1, input int n2,
                             input int hold, input bit stray);
        logic need1, need2;
        logic [31:0] e1, e2;
        model_needs(ins, need1, need2);
        e1 = need1 ? regs[ins[19:15]] : 32'd0;
        e2 = need2 ? regs[ins[24:20]] : 32'd0;
        accept_instr(ins);
        if (need1) begin
            serve(ins[19:15], n1);
            if (need2) begin
                check("gap_rd_en", bus.rf_rd_en, 0);
                check("gap_op_valid", bus.op_valid, 0);
                @(negedge clk);
            end
        end
        if (need2) serve(ins[24:20], n2);
        for (int h = 0; h <= hold; h++) begin
            check("op_valid", bus.op_valid, 1);
            check("op_instr", bus.op_instr, ins);
            check("rs1_data", bus.rs1_data, e1);
            check("rs2_data", bus.rs2_data, e2);
            check("hold_rd_en", bus.rf_rd_en, 0);
            check("hold_ready", bus.instr_ready, 0);
            check("err_quiet", bus.err, 0);
            bus.op_ready    = (h == hold);
            bus.rf_rd_valid = stray && (h != hold);
            bus.rf_reg_data = $urandom;
            @(negedge clk);
            bus.rf_rd_valid = 1'b0;
        end
        bus.op_ready = 1'b0;
        check("post_op_valid", bus.op_valid, 0);
        check("post_ready", bus.instr_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    bus.instr_ready, 1);
        check({tag, "_rd_en"},    bus.rf_rd_en, 0);
        check({tag, "_addr"},     bus.rf_reg_addr, 0);
        check({tag, "_op_valid"}, bus.op_valid, 0);
        check({tag, "_instr"},    bus.op_instr, 0);
        check({tag, "_rs1"},      bus.rs1_data, 0);
        check({tag, "_rs2"},      bus.rs2_data, 0);
        check({tag, "_err"},      bus.err, 0);
    endtask

    logic [6:0] opcs [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0100011,
                              7'b1100011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011};

    initial begin
        logic [31:0] ins;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.rf_reg_data = '0;
        bus.rf_rd_valid = 1'b0;
        bus.op_ready    = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'h11;
        regs[2] = 32'h22;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_instr(32'h002081B3, 2, 2, 0, 1'b0);   // ADD x3,x1,x2
        run_instr(32'h123452B7, 1, 1, 0, 1'b0);   // LUI x5,0x12345
        run_instr(32'h00500093, 1, 1, 0, 1'b0);   // ADDI x1,x0,5
        run_instr(32'h0020A023, 1, 3, 5, 1'b1);   // SW x2,0(x1), execute stalls
        run_instr(32'h002081B3, RD_TIMEOUT, 1, 0, 1'b0);

        // Read never completes: error pulse after RD_TIMEOUT cycles
        accept_instr(32'h002081B3);
        for (int k = 1; k <= RD_TIMEOUT; k++) begin
            check("tmo_rd_en", bus.rf_rd_en, 1);
            check("tmo_err_early", bus.err, 0);
            @(negedge clk);
        end
        check("tmo_err", bus.err, 1);
        check("tmo_rd_en_off", bus.rf_rd_en, 0);
        check("tmo_ready", bus.instr_ready, 1);
        check("tmo_op_valid", bus.op_valid, 0);
        @(negedge clk);
        check("tmo_err_pulse", bus.err, 0);
        run_instr(32'h123452B7, 1, 1, 0, 1'b0);

        // Reset while the rs2 read is outstanding
        accept_instr(32'h002081B3);
        serve(5'd1, 1);
        check("rst_gap", bus.rf_rd_en, 0);
        @(negedge clk);
        check("rst_rd2_en", bus.rf_rd_en, 1);
        check("rst_rd2_addr", bus.rf_reg_addr, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_idle", bus.instr_ready, 1);

        for (int t = 0; t < 40; t++) begin
            ins = $urandom;
            ins[6:0] = opcs[$urandom_range(0, 9)];
            if ($urandom_range(0, 5) == 0) ins[19:15] = 5'd0;
            if ($urandom_range(0, 5) == 0) ins[24:20] = 5'd0;
            run_instr(ins, $urandom_range(1, 4), $urandom_range(1, 4),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
